// File: rtl/cla_seq_adder_pkg.sv
// Purpose : shared types and constants for the sequential CLA adder.
// Contents: NIBBLE_W (width of one lookahead slice) and the controller
//           state encoding (IDLE/RUN/DONE).
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_if.sv
// Purpose : requester <-> adder handshake bundle.
// Signals : start, A, B, Cin, Sub (requester -> adder);
//           busy, done, F, ovf    (adder -> requester).
// Modports: master = requester side, slave = adder side.
interface cla_seq_adder_if #(
  parameter int NIBBLES = 4
);

  logic                   start;
  logic [4*NIBBLES-1:0]   A;
  logic [4*NIBBLES-1:0]   B;
  logic                   Cin;
  logic                   Sub;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES:0]     F;
  logic                   ovf;

  modport master (
    output start, A, B, Cin, Sub,
    input  busy, done, F, ovf
  );

  modport slave (
    input  start, A, B, Cin, Sub,
    output busy, done, F, ovf
  );

endinterface

// File: rtl/cla_seq_adder_slice.sv
// Purpose : purely combinational 4-bit carry-lookahead adder slice.
// Ports   : i_a[3:0], i_b[3:0], i_cin -> o_s[3:0], o_cout.
// All internal carries are computed directly from propagate/generate
// terms and the slice carry-in, so no carry ripples inside the nibble.
module cla_slice_4
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_s,
  output logic                o_cout
);

  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W:0]   w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_s    = w_p ^ w_c[NIBBLE_W-1:0];
  assign o_cout = w_c[NIBBLE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Purpose : multi-cycle add/sub of 4*NIBBLES-bit operands through one
//           shared 4-bit CLA slice, least-significant nibble first.
// Ports   : clk   - rising-edge clock
//           rst_n - synchronous active-low reset
//           bus   - cla_seq_adder_if.slave (start/A/B/Cin/Sub in,
//                   busy/done/F/ovf out)
// Timing  : accept at edge 0, nibble k processed at edge k+1, done high
//           for one cycle after edge NIBBLES, idle again after NIBBLES+1.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  cla_seq_adder_if.slave bus
);

  localparam int                IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t r_state;
  state_t w_next_state;

  // Operands and result viewed as arrays of nibbles so the slice mux is
  // a plain index by r_idx.
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_op_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_op_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_sum;
  logic                             r_cout;
  logic                             r_carry;
  logic                             r_ovf;
  logic [IDX_W-1:0]                 r_idx;

  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_last;

  assign w_last = (r_idx == LAST_IDX);

  cla_slice_4 u_slice (
    .i_a    (r_op_a[r_idx]),
    .i_b    (r_op_b[r_idx]),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default at the top of the block covers every path, so no
  // latch is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the operand registers are deliberately left out of reset; they are
  // always loaded on accept before being read, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.A;
            // Subtraction is A + ~B + 1: invert B here and force carry-in.
            r_op_b  <= bus.Sub ? ~bus.B : bus.B;
            r_carry <= bus.Cin | bus.Sub;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx] <= w_sum;
          r_carry      <= w_cout;
          if (w_last) begin
            r_cout <= w_cout;
            // Overflow: operands share a sign but the result sign differs.
            r_ovf  <= (r_op_a[NIBBLES-1][NIBBLE_W-1] == r_op_b[NIBBLES-1][NIBBLE_W-1])
                   && (w_sum[NIBBLE_W-1] != r_op_a[NIBBLES-1][NIBBLE_W-1]);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.F    = {r_cout, r_sum};
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder with NIBBLES=4.
module tb_cla_seq_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cla_seq_adder_if #(.NIBBLES(N)) bus ();

  cla_seq_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W:0]   f;
    logic         ovf;
    bit           chk_carry;
  } vec_t;

  typedef struct packed {
    logic [W:0] f;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         m;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb    = sub ? ~b : b;
    s     = {1'b0, a} + {1'b0, bb} + (W+1)'(cin | sub);
    m.f   = s;
    m.ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return m;
  endfunction

  // Drive one operation, wait (bounded) for done, compare against the
  // scoreboard entry pushed at issue time.
  task automatic run_op(input vec_t v);
    exp_t e;
    int   n;
    bit   seen;
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.A     = v.a;
    bus.B     = v.b;
    bus.Cin   = v.cin;
    bus.Sub   = v.sub;
    bus.start = 1'b1;
    sb_q.push_back('{f: v.f, ovf: v.ovf});
    @(posedge clk);
    #1 bus.start = 1'b0;
    check({v.name, " busy after accept"}, bus.busy, 1);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (v.chk_carry && i <= N)
        check($sformatf("%s carry after RUN edge %0d", v.name, i), dut.r_carry, 1);
      if (bus.done) begin
        seen = 1'b1;
        n    = i;
      end
    end
    check({v.name, " done latency"}, n, N);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({v.name, " F"}, bus.F, e.f);
      check({v.name, " ovf"}, bus.ovf, e.ovf);
    end
    @(posedge clk);
    #1;
    check({v.name, " busy after done"}, bus.busy, 0);
    check({v.name, " done single pulse"}, bus.done, 0);
  endtask

  vec_t vecs[7];
  vec_t rv;
  exp_t me;
  exp_t e;
  int   dones;

  initial begin
    vecs[0] = '{"add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 1'b0, 1'b0};
    vecs[1] = '{"add_cin",  16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001, 1'b0, 1'b0};
    vecs[2] = '{"ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1};
    vecs[3] = '{"ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 1'b0};
    vecs[4] = '{"ovf_neg",  16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1, 1'b0};
    vecs[5] = '{"sub_5_7",  16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 1'b0, 1'b0};
    vecs[6] = '{"sub_7_5",  16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 1'b0, 1'b0};

    // Reset held with start asserted.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0001;
    bus.Cin   = 1'b1;
    bus.Sub   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset F", bus.F, 17'h0);
    check("reset ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle without start", bus.busy, 0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Random operations against the reference model.
    for (int k = 0; k < 4; k++) begin
      rv.name = $sformatf("rand%0d", k);
      rv.a    = W'($urandom);
      rv.b    = W'($urandom);
      rv.cin  = 1'($urandom);
      rv.sub  = 1'($urandom);
      me      = model(rv.a, rv.b, rv.cin, rv.sub);
      rv.f    = me.f;
      rv.ovf  = me.ovf;
      rv.chk_carry = 1'b0;
      run_op(rv);
    end

    // start pulsed during RUN and during DONE must be ignored.
    dones = 0;
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h1111; bus.Cin = 1'b0; bus.Sub = 1'b0;
    bus.start = 1'b1;
    sb_q.push_back(model(16'h1234, 16'h1111, 1'b0, 1'b0));
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= N + 4; i++) begin
      @(negedge clk);
      bus.start = (i == 2) || (i == N + 1);
      bus.A     = 16'hFFFF;
      bus.B     = 16'hFFFF;
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("hs F", bus.F, e.f);
          check("hs ovf", bus.ovf, e.ovf);
        end
      end
      if (i >= N + 1) check($sformatf("hs busy edge %0d", i), bus.busy, 0);
    end
    bus.start = 1'b0;
    check("hs done count", dones, 1);

    // Reset at the 2nd RUN edge aborts without done.
    @(negedge clk);
    bus.A = 16'h00FF; bus.B = 16'h0001; bus.Cin = 1'b0; bus.Sub = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", bus.busy, 0);
    check("abort F", bus.F, 17'h0);
    check("abort ovf", bus.ovf, 0);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (bus.done) dones++;
    end
    check("abort no done", dones, 0);
    run_op('{"after_abort", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle adder/subtractor controller that sequences one shared 4-bit carry-lookahead slice across a wide operand, one nibble per clock, least-significant nibble first.
- Carry is registered between nibbles; the slice's lookahead logic is used within each nibble.
- Sits between a requester using a start/busy/done handshake and the 4-bit CLA datapath, giving wide add/sub at the area cost of a single slice.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width is 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; accepted only when busy=0
- A  input  4*NIBBLES  operand A, sampled on the accepting edge
- B  input  4*NIBBLES  operand B, sampled on the accepting edge
- Cin  input  1  carry-in for add; ignored when Sub=1
- Sub  input  1  1 = compute A-B, 0 = compute A+B+Cin; sampled with operands
- busy  output  1  high from the accepting edge until the return to IDLE
- done  output  1  one-cycle pulse; F and ovf are valid while it is high
- F  output  4*NIBBLES+1  result; MSB is the final carry-out (for Sub, 1 = no borrow)
- ovf  output  1  two's-complement signed overflow of the completed operation

Behaviour:
- Reset: when rst_n=0 at a rising edge, state goes to IDLE and busy=0, done=0, F=0, ovf=0, nibble index=0, carry register=0. Reset applies mid-operation with the same effect; no done is produced for the aborted operation.
- States:
  - IDLE: busy=0. If start=1, latch A into opA; latch B into opB when Sub=0, or ~B when Sub=1; carry <= Cin|Sub; idx <= 0; go to RUN. If start=0, stay in IDLE.
  - RUN: busy=1. The slice adds opA[idx] nibble + opB[idx] nibble + carry. The sum nibble is written into F[4*idx+3:4*idx] and carry <= slice carry-out. If idx==NIBBLES-1: F[4*NIBBLES] <= carry-out, ovf <= (opA msb == opB msb) && (sum msb != opA msb), go to DONE. Otherwise idx <= idx+1.
  - DONE: busy=1, done=1 for exactly this cycle; unconditionally go to IDLE.
- Latency: with start sampled at edge 0, nibbles 0..NIBBLES-1 are processed at edges 1..NIBBLES. done is high in the cycle after edge NIBBLES. busy falls after edge NIBBLES+1. Earliest next accept is edge NIBBLES+2 (start must be seen with busy=0).
- start while busy=1, including the DONE cycle, is ignored and is not queued. Input changes while busy have no effect.
- F and ovf hold their final values from DONE until the next accepted start or reset. Partial F nibbles update during RUN; F is only defined when done=1 or while idle after completion.
- Idx counter width is clog2(NIBBLES). It never wraps past NIBBLES-1.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Decomposition:
- Package cla_seq_pkg: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2; NIBBLE_W=4.
- Sub-module cla_slice_4: purely combinational 4-bit CLA (A[3:0], B[3:0], Cin -> S[3:0], Cout) with per-bit P/G and full lookahead carries. Instantiated once; the controller muxes nibbles into it.
- The controller FSM, operand/result registers and index counter stay in cla_seq_adder.

Test Plan (NIBBLES=4):
- Reset: hold rst_n=0 for 2 edges with start=1 -> busy=0, done=0, F=17'h0, ovf=0. Release -> an operation starts only on the next start edge.
- Add: A=16'h00FF, B=16'h0001, Cin=0, Sub=0, start 1 cycle -> busy=1 next cycle, done only in the cycle after edge 4, F=17'h00100, ovf=0. Also A=0, B=0, Cin=1 -> F=17'h00001.
- Full carry ripple: A=16'hFFFF, B=16'h0001 -> F=17'h10000, ovf=0. Check the carry register is 1 after each of the 4 RUN edges.
- Signed overflow: A=16'h7FFF, B=16'h0001 -> F=17'h08000, ovf=1. Also A=16'h8000, B=16'h8000 -> F=17'h10000, ovf=1.
- Subtract: A=16'h0005, B=16'h0007, Sub=1, Cin=1 (ignored) -> F=17'h0FFFE, ovf=0. Also A=16'h0007, B=16'h0005 -> F=17'h10002.
- Handshake/abort: pulse start again during RUN and in DONE -> ignored, exactly one done. Start a new op, drop rst_n at the 2nd RUN edge -> IDLE next cycle, F=0, no done; a subsequent op completes correctly.
